// File: rtl/stage_fq.sv
// rtl/stage_fq.sv - fetch queue between instruction fetch and decode
// Circular buffer of {pc, instr, misalign}; fullness tracked by count, not pointers.
module stage_fq #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fq_flush,
  input  logic             in_valid,
  input  logic [63:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [63:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic             out_misalign,
  input  logic             out_ready,
  output logic [PTR_W:0]   fq_count
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [63:0]      mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic             mem_mis   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  // in_ready depends on count only, so a full queue never passes a beat through
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign fq_count  = count;
  assign push      = in_valid & in_ready & ~fq_flush;
  assign pop       = out_valid & out_ready & ~fq_flush;

  assign out_pc       = out_valid ? mem_pc[rd_ptr]    : '0;
  assign out_instr    = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_misalign = out_valid ? mem_mis[rd_ptr]   : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
        mem_mis[i]   <= 1'b0;
      end
    end else if (fq_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]    <= in_pc;
        mem_instr[wr_ptr] <= in_instr;
        mem_mis[wr_ptr]   <= |in_pc[1:0];
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_fq.sv
// tb/tb_stage_fq.sv - directed self-checking bench for stage_fq
module tb_stage_fq;

  logic        clk = 1'b0;
  logic        rst;
  logic        fq_flush;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;
  logic        out_ready;
  logic [2:0]  fq_count;

  int n_tests = 0;
  int n_fail  = 0;

  stage_fq #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .fq_flush(fq_flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_misalign(out_misalign), .out_ready(out_ready), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [63:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = pc[31:0] ^ 32'h0000_0013;
    step();
    in_valid = 1'b0;
  endtask

  logic [63:0] exp_q[$];
  logic [63:0] pc_v;
  int          sent;
  int          recv;
  int          mcount;
  bit          m_push;
  bit          m_pop;

  initial begin
    rst = 1'b1; fq_flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", fq_count, 0);
    check("rst_out_pc", out_pc, 0);

    // single beat, visible one cycle after push
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 64'h8000_0000; in_instr = 32'h0000_0013;
    check("single_no_bypass", out_valid, 0);
    step();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_pc", out_pc, 64'h8000_0000);
    check("single_instr", out_instr, 32'h0000_0013);
    check("single_mis", out_misalign, 0);
    step();
    check("single_count0", fq_count, 0);

    // fill with backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(64'h8000_0000 + 64'(4 * i));
    check("fill_count", fq_count, 4);
    check("fill_in_ready", in_ready, 0);
    push_beat(64'h8000_0010);
    check("fill_5th_rejected", fq_count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_pop%0d", i), out_pc, 64'h8000_0000 + 64'(4 * i));
      step();
    end
    check("fill_drained", fq_count, 0);
    check("fill_drained_valid", out_valid, 0);

    // simultaneous push and pop when full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(64'h8000_0020 + 64'(4 * i));
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_0040; in_instr = 32'h13;
    step();
    check("full_pp_count", fq_count, 3);
    check("full_pp_head", out_pc, 64'h8000_0024);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("full_pp_push", fq_count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_pp_pop%0d", i), out_pc,
            (i == 3) ? 64'h8000_0040 : 64'h8000_0024 + 64'(4 * i));
      step();
    end
    check("full_pp_drained", fq_count, 0);

    // flush with concurrent push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_beat(64'h8000_0080 + 64'(4 * i));
    check("flush_pre_count", fq_count, 3);
    fq_flush = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_0100;
    step();
    fq_flush = 1'b0; in_valid = 1'b0;
    check("flush_count", fq_count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_out_pc", out_pc, 0);
    push_beat(64'h8000_0200);
    check("flush_new_head", out_pc, 64'h8000_0200);
    check("flush_new_count", fq_count, 1);
    out_ready = 1'b1;
    step();
    check("flush_post_drain", fq_count, 0);

    // reset mid-operation
    out_ready = 1'b0;
    push_beat(64'h8000_0300);
    push_beat(64'h8000_0304);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_count", fq_count, 0);
    check("midrst_pc", out_pc, 0);

    // wrap with random backpressure, one misaligned beat
    sent = 0; recv = 0; mcount = 0;
    for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      pc_v      = (sent == 5) ? 64'h8000_0002 : 64'h8000_1000 + 64'(4 * sent);
      in_pc     = pc_v;
      in_instr  = 32'h13;
      check("wrap_valid", out_valid, (mcount != 0));
      if (mcount != 0) begin
        check("wrap_pc", out_pc, exp_q[0]);
        check("wrap_mis", out_misalign, (exp_q[0][1:0] != 2'b00));
      end
      m_push = in_valid && (mcount < 4);
      m_pop  = out_ready && (mcount != 0);
      step();
      if (m_pop) begin
        void'(exp_q.pop_front());
        mcount--;
        recv++;
      end
      if (m_push) begin
        exp_q.push_back(pc_v);
        mcount++;
        sent++;
      end
    end
    in_valid = 1'b0;
    check("wrap_received", recv, 10);
    check("wrap_final_count", fq_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_fq.md
Name: stage_fq

Overview:
- Fetch queue stage between the instruction-fetch stage and the decode stage.
- Buffers {pc, instr} pairs produced by fetch, so decode backpressure does not lose fetched instructions.
- On a redirect (branch, jump or trap), flush discards every buffered entry.
- Each entry is tagged with an instruction-address-misaligned flag for the downstream exception logic.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- fq_flush  input  1  discard all entries and the current input beat.
- in_valid  input  1  fetch presents a valid {pc, instr}.
- in_pc  input  64  fetched PC.
- in_instr  input  32  fetched instruction word.
- in_ready  output  1  queue accepts a beat this cycle.
- out_valid  output  1  head entry is valid.
- out_pc  output  64  head PC.
- out_instr  output  32  head instruction.
- out_misalign  output  1  head PC[1:0] != 0.
- out_ready  input  1  decode consumes the head this cycle.
- fq_count  output  PTR_W+1  number of occupied entries.

Behaviour:
- Clock and reset: single clock domain, clk; rst is synchronous and active-high.
- Reset:
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - out_valid = 0, in_ready = 1, fq_count = 0.
  - out_pc, out_instr and out_misalign read as 0 while the queue is empty.
- Storage: circular buffer of DEPTH entries, each {pc[63:0], instr[31:0], misalign}.
  - misalign is computed at push as |in_pc[1:0].
- in_ready = (count < DEPTH). It is combinational from count only and never depends on out_ready: no pass-through when full.
- Push: occurs when in_valid & in_ready & ~fq_flush. The entry is written at wr_ptr, then wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid & out_ready & ~fq_flush; rd_ptr then increments modulo DEPTH.
- out_valid = (count != 0). The out_* fields are a combinational read of the entry at rd_ptr and are zero-forced when empty.
- Latency: a pushed beat is visible at the output the cycle after the push. There is no same-cycle bypass, so minimum latency is 1 cycle.
- Simultaneous push and pop:
  - With 0 < count < DEPTH, both take effect and count is unchanged.
  - When full, no push occurs (in_ready = 0); the pop still occurs and count drops to DEPTH-1.
  - When empty, no pop occurs; the push occurs and count becomes 1.
- Flush:
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0.
  - Any in_valid beat in the flush cycle is dropped.
  - A pop in the flush cycle is not counted as consumed; decode must ignore it.
  - Flush has priority over push and pop.
- Reset mid-operation: behaves identically to flush and also clears the entry storage.
- Pointer wrap: pointers are PTR_W bits and wrap naturally. Full/empty is determined from count, not from pointer equality.
- Invariants: count is never greater than DEPTH and never underflows.
- Ordering: entries leave in exactly the order they entered.
- Stall mapping: fetch holds its PC when ~in_ready, i.e. ~in_ready drives the fetch-stage stall.

Test Plan:
- Reset then idle: rst high for 2 cycles -> out_valid = 0, in_ready = 1, fq_count = 0, out_pc = 0.
- Single beat: push pc = 0x80000000, instr = 0x00000013 with out_ready = 1 -> out_valid rises the next cycle with those values and out_misalign = 0; fq_count returns to 0 after the pop.
- Fill with backpressure: out_ready = 0, push pcs 0x80000000, 0x80000004, 0x80000008, 0x8000000C -> fq_count = 4, in_ready = 0. A 5th beat at 0x80000010 is not accepted. Then out_ready = 1 for 4 cycles -> pops return pcs in order 0x...00, 0x...04, 0x...08, 0x...0C.
- Simultaneous push and pop at full: count = 4, in_valid = 1, out_ready = 1 -> head pops, no push, fq_count = 3. The next cycle the push is accepted and fq_count = 3 (push and pop again) or 4 (no pop).
- Flush with concurrent push: count = 3, fq_flush = 1 with in_valid = 1 at pc = 0x80000100 -> next cycle fq_count = 0, out_valid = 0. A subsequent push of 0x80000200 appears at the head with no stale data.
- Wrap and misalign: stream 10 beats through DEPTH = 4 with random out_ready; one beat has pc = 0x80000002 -> output order is preserved across the pointer wrap, and out_misalign = 1 only on that beat.
